// File: rtl/uc_mc_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// ALU operation codes, ALU op classes and datapath mux select codes.
// UC_MC_ILLEGAL_TRAP_EN adds the StTrap state for unknown opcodes.
`timescale 1ns / 1ps

package uc_mc_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StJal      = 4'd9,
        StBranch   = 4'd10,
        StErr      = 4'd11
`ifdef UC_MC_ILLEGAL_TRAP_EN
        ,StTrap    = 4'd12
`endif
    } ucState_e;

    // Opcodes (IR[6:0])
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    // ALUControl codes
    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluSlt  = 4'd5;
    localparam logic [3:0] AluSltu = 4'd6;
    localparam logic [3:0] AluSll  = 4'd7;
    localparam logic [3:0] AluSrl  = 4'd8;
    localparam logic [3:0] AluSra  = 4'd9;

    // ALU op classes
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    // Result mux
    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    // ALU A / B muxes
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcBRs2   = 2'b00;
    localparam logic [1:0] SrcBImm   = 2'b01;
    localparam logic [1:0] SrcBFour  = 2'b10;

    // Immediate formats
    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    // Immediate format follows the opcode alone, independent of FSM state
    function automatic logic [1:0] immSel(input logic [6:0] opc);
        logic [1:0] sel;
        case (opc)
            OpLoad, OpImm: sel = ImmI;
            OpStore:       sel = ImmS;
            OpBranch:      sel = ImmB;
            OpJal:         sel = ImmJ;
            default:       sel = ImmI;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_deco_ext.sv
// ALU decoder: maps an ALU op class plus op[5]/funct3/funct7[5] to an
// ALUControl code, zero-extended to ALU_CTRL_W bits.
`timescale 1ns / 1ps

module alu_deco_ext
    import uc_mc_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 4
) (
    input  logic [1:0]            aluOp,
    input  logic                  op5,
    input  logic [2:0]            f3,
    input  logic                  f7,
    output logic [ALU_CTRL_W-1:0] aluControl
);

    logic [3:0] code;

    // Class decode; funct class resolves the operation from funct3/funct7
    always_comb begin
        code = AluAdd;
        unique case (aluOp)
            AluOpAdd: code = AluAdd;
            AluOpSub: code = AluSub;
            AluOpFunct: begin
                unique case (f3)
                    3'b000: code = (op5 & f7) ? AluSub : AluAdd;
                    3'b001: code = AluSll;
                    3'b010: code = AluSlt;
                    3'b011: code = AluSltu;
                    3'b100: code = AluXor;
                    3'b101: code = f7 ? AluSra : AluSrl;
                    3'b110: code = AluOr;
                    3'b111: code = AluAnd;
                endcase
            end
            default: code = AluAdd;
        endcase
    end

    assign aluControl = ALU_CTRL_W'(code);

endmodule

// File: rtl/uc_multicycle.sv
// Multicycle RV32I control unit: Moore FSM over a shared memory port with a
// ready handshake and timeout, full branch set and extended ALU decode.
// UC_MC_ILLEGAL_TRAP_EN: unknown opcodes trap (illegal=1, held until reset);
// when undefined they retire as NOPs and illegal is tied low.
`timescale 1ns / 1ps

module uc_multicycle
    import uc_mc_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W  = 4,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            op,
    input  logic [2:0]            f3,
    input  logic                  f7,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  pcWrite,
    output logic                  adrSrc,
    output logic                  memRead,
    output logic                  memWrite,
    output logic                  irWrite,
    output logic [1:0]            resSrc,
    output logic [1:0]            aluSrcA,
    output logic [1:0]            aluSrcB,
    output logic [1:0]            inmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  regWrite,
    output logic                  instr_done,
    output logic                  bus_err,
    output logic                  illegal
);

    localparam logic [TO_CNT_W-1:0] ToLimit = TO_CNT_W'(MEM_TIMEOUT);

    ucState_e              stateQ, stateD;
    logic [TO_CNT_W-1:0]   toCntQ, toCntD, toCntInc;
    logic [1:0]            aluOp;
    logic                  aluOp5;
    logic [ALU_CTRL_W-1:0] aluCtrlDec;
    logic                  waiting;
    logic                  taken;

    assign toCntInc = toCntQ + TO_CNT_W'(1);

    // Branch resolution from funct3 and comparator flags
    always_comb begin
        unique case (f3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

    // Next state, timeout counter and Moore outputs
    always_comb begin
        stateD     = stateQ;
        waiting    = 1'b0;
        pcWrite    = 1'b0;
        adrSrc     = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        resSrc     = ResAluOut;
        aluSrcA    = SrcAPc;
        aluSrcB    = SrcBRs2;
        inmSrc     = immSel(op);
        aluOp      = AluOpAdd;
        aluOp5     = op[5];
        regWrite   = 1'b0;
        instr_done = 1'b0;
        bus_err    = 1'b0;
        illegal    = 1'b0;

        unique case (stateQ)
            StFetch: begin
                memRead = 1'b1;
                if (mem_ready) begin
                    irWrite = 1'b1;
                    aluSrcA = SrcAPc;
                    aluSrcB = SrcBFour;
                    resSrc  = ResAluResult;
                    pcWrite = 1'b1;
                    stateD  = StDecode;
                end else begin
                    waiting = 1'b1;
                end
            end
            StDecode: begin
                // Precompute oldPC + imm into ALUOut for branch/jump targets
                aluSrcA = SrcAOldPc;
                aluSrcB = SrcBImm;
                case (op)
                    OpLoad, OpStore: stateD = StMemAdr;
                    OpRType:         stateD = StExecR;
                    OpImm:           stateD = StExecI;
                    OpJal:           stateD = StJal;
                    OpBranch:        stateD = StBranch;
                    default: begin
`ifdef UC_MC_ILLEGAL_TRAP_EN
                        stateD = StTrap;
`else
                        instr_done = 1'b1;
                        stateD     = StFetch;
`endif
                    end
                endcase
            end
            StMemAdr: begin
                aluSrcA = SrcARs1;
                aluSrcB = SrcBImm;
                stateD  = op[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                adrSrc  = 1'b1;
                memRead = 1'b1;
                if (mem_ready) stateD = StMemWb;
                else           waiting = 1'b1;
            end
            StMemWb: begin
                resSrc     = ResData;
                regWrite   = 1'b1;
                instr_done = 1'b1;
                stateD     = StFetch;
            end
            StMemWrite: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    stateD     = StFetch;
                end else begin
                    waiting = 1'b1;
                end
            end
            StExecR: begin
                aluSrcA = SrcARs1;
                aluSrcB = SrcBRs2;
                aluOp   = AluOpFunct;
                stateD  = StAluWb;
            end
            StExecI: begin
                // op[5] masked so funct7 never turns addi into sub
                aluSrcA = SrcARs1;
                aluSrcB = SrcBImm;
                aluOp   = AluOpFunct;
                aluOp5  = 1'b0;
                stateD  = StAluWb;
            end
            StAluWb: begin
                resSrc     = ResAluOut;
                regWrite   = 1'b1;
                instr_done = 1'b1;
                stateD     = StFetch;
            end
            StJal: begin
                // PC <- target held in ALUOut; ALU forms the link oldPC + 4
                aluSrcA = SrcAOldPc;
                aluSrcB = SrcBFour;
                resSrc  = ResAluOut;
                pcWrite = 1'b1;
                stateD  = StAluWb;
            end
            StBranch: begin
                aluSrcA    = SrcARs1;
                aluSrcB    = SrcBRs2;
                aluOp      = AluOpSub;
                resSrc     = ResAluOut;
                pcWrite    = taken;
                instr_done = 1'b1;
                stateD     = StFetch;
            end
            StErr: begin
                inmSrc  = ImmI;
                bus_err = 1'b1;
            end
`ifdef UC_MC_ILLEGAL_TRAP_EN
            StTrap: begin
                inmSrc  = ImmI;
                illegal = 1'b1;
            end
`endif
            default: stateD = StFetch;
        endcase

        // mem_ready on the limiting cycle wins; MEM_TIMEOUT == 0 disables
        if (waiting && (MEM_TIMEOUT != 0) && (toCntInc == ToLimit)) begin
            stateD = StErr;
        end
        toCntD = (stateD != stateQ) ? '0 : (waiting ? toCntInc : toCntQ);

        if (reset) begin
            pcWrite    = 1'b0;
            adrSrc     = 1'b0;
            memRead    = 1'b0;
            memWrite   = 1'b0;
            irWrite    = 1'b0;
            resSrc     = '0;
            aluSrcA    = '0;
            aluSrcB    = '0;
            inmSrc     = '0;
            regWrite   = 1'b0;
            instr_done = 1'b0;
            bus_err    = 1'b0;
            illegal    = 1'b0;
        end
    end

    // State and timeout counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= StFetch;
            toCntQ <= '0;
        end else begin
            stateQ <= stateD;
            toCntQ <= toCntD;
        end
    end

    alu_deco_ext #(
        .ALU_CTRL_W(ALU_CTRL_W)
    ) uAluDeco (
        .aluOp     (aluOp),
        .op5       (aluOp5),
        .f3        (f3),
        .f7        (f7),
        .aluControl(aluCtrlDec)
    );

    assign ALUControl = reset ? '0 : aluCtrlDec;

endmodule

// File: tb/tb_uc_multicycle.sv
// Directed bench for uc_multicycle: walks each instruction class cycle by
// cycle and compares the full control vector against hand-built values.
`timescale 1ns / 1ps

module tb_uc_multicycle;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, zero, lt, ltu, mem_ready;
    logic       pcWrite, adrSrc, memRead, memWrite, irWrite;
    logic [1:0] resSrc, aluSrcA, aluSrcB, inmSrc;
    logic [3:0] ALUControl;
    logic       regWrite, instr_done, bus_err, illegal;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    uc_multicycle #(
        .ALU_CTRL_W (4),
        .MEM_TIMEOUT(15),
        .TO_CNT_W   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .f3        (f3),
        .f7        (f7),
        .zero      (zero),
        .lt        (lt),
        .ltu       (ltu),
        .mem_ready (mem_ready),
        .pcWrite   (pcWrite),
        .adrSrc    (adrSrc),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .irWrite   (irWrite),
        .resSrc    (resSrc),
        .aluSrcA   (aluSrcA),
        .aluSrcB   (aluSrcB),
        .inmSrc    (inmSrc),
        .ALUControl(ALUControl),
        .regWrite  (regWrite),
        .instr_done(instr_done),
        .bus_err   (bus_err),
        .illegal   (illegal)
    );

    // {pcWrite,adrSrc,memRead,memWrite,irWrite, resSrc, A, B, inmSrc, ALUControl,
    //  regWrite,instr_done,bus_err,illegal}
    logic [20:0] ctrl;
    assign ctrl = {pcWrite, adrSrc, memRead, memWrite, irWrite, resSrc, aluSrcA, aluSrcB,
                   inmSrc, ALUControl, regWrite, instr_done, bus_err, illegal};

    task automatic checkEq(input string tag, input logic [20:0] got, input logic [20:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] mk(input logic [4:0] c, input logic [1:0] res,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] imm, input logic [3:0] alu,
                                       input logic [3:0] tail);
        return {c, res, a, b, imm, alu, tail};
    endfunction

    function automatic logic [20:0] vFetchGo(input logic [1:0] imm);
        return mk(5'b10101, 2'b10, 2'b00, 2'b10, imm, 4'd0, 4'b0000);
    endfunction
    function automatic logic [20:0] vFetchWait(input logic [1:0] imm);
        return mk(5'b00100, 2'b00, 2'b00, 2'b00, imm, 4'd0, 4'b0000);
    endfunction
    function automatic logic [20:0] vDecode(input logic [1:0] imm, input logic done);
        return mk(5'b00000, 2'b00, 2'b01, 2'b01, imm, 4'd0, {1'b0, done, 2'b00});
    endfunction
    function automatic logic [20:0] vAluWb(input logic [1:0] imm);
        return mk(5'b00000, 2'b00, 2'b00, 2'b00, imm, 4'd0, 4'b1100);
    endfunction

    task automatic chk(input string tag, input logic [20:0] exp);
        #1;
        checkEq(tag, ctrl, exp);
    endtask

    task automatic nextCyc();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string tag, input logic [20:0] afterExp);
        reset = 1'b1;
        chk({tag, "-async"}, '0);
        nextCyc();
        chk({tag, "-held"}, '0);
        reset = 1'b0;
        chk({tag, "-rel"}, afterExp);
    endtask

    task automatic runR(input string tag, input logic [6:0] opc, input logic [2:0] a3,
                        input logic a7, input logic [3:0] alu);
        op = opc; f3 = a3; f7 = a7; mem_ready = 1'b1;
        chk({tag, "-fetch"}, vFetchGo(2'b00));
        nextCyc();
        chk({tag, "-decode"}, vDecode(2'b00, 1'b0));
        nextCyc();
        // R-type uses rs2, I-type uses the immediate
        chk({tag, "-exec"}, mk(5'b00000, 2'b00, 2'b10, opc[5] ? 2'b00 : 2'b01, 2'b00, alu,
                              4'b0000));
        nextCyc();
        chk({tag, "-wb"}, vAluWb(2'b00));
        nextCyc();
    endtask

    task automatic runBr(input string tag, input logic [2:0] a3, input logic z,
                         input logic l, input logic lu, input logic tk);
        op = 7'b1100011; f3 = a3; zero = z; lt = l; ltu = lu; mem_ready = 1'b1;
        chk({tag, "-fetch"}, vFetchGo(2'b10));
        nextCyc();
        chk({tag, "-decode"}, vDecode(2'b10, 1'b0));
        nextCyc();
        chk({tag, "-branch"}, mk({tk, 4'b0000}, 2'b00, 2'b10, 2'b00, 2'b10, 4'd1, 4'b0100));
        nextCyc();
    endtask

    task automatic runLw(input string tag, input int fetchWaits, input int readWaits);
        op = 7'b0000011; f3 = 3'b010; f7 = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < fetchWaits; i++) begin
            chk({tag, "-fwait"}, vFetchWait(2'b00));
            nextCyc();
        end
        mem_ready = 1'b1;
        chk({tag, "-fetch"}, vFetchGo(2'b00));
        nextCyc();
        chk({tag, "-decode"}, vDecode(2'b00, 1'b0));
        nextCyc();
        chk({tag, "-memadr"}, mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 4'd0, 4'b0000));
        nextCyc();
        mem_ready = 1'b0;
        for (int i = 0; i < readWaits; i++) begin
            chk({tag, "-rwait"}, mk(5'b01100, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 4'b0000));
            nextCyc();
        end
        mem_ready = 1'b1;
        chk({tag, "-read"}, mk(5'b01100, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 4'b0000));
        nextCyc();
        chk({tag, "-memwb"}, mk(5'b00000, 2'b01, 2'b00, 2'b00, 2'b00, 4'd0, 4'b1100));
        nextCyc();
    endtask

    task automatic runSw(input string tag, input int writeWaits);
        op = 7'b0100011; f3 = 3'b010; f7 = 1'b0; mem_ready = 1'b1;
        chk({tag, "-fetch"}, vFetchGo(2'b01));
        nextCyc();
        chk({tag, "-decode"}, vDecode(2'b01, 1'b0));
        nextCyc();
        chk({tag, "-memadr"}, mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 4'd0, 4'b0000));
        nextCyc();
        mem_ready = 1'b0;
        for (int i = 0; i < writeWaits; i++) begin
            chk({tag, "-wwait"}, mk(5'b01010, 2'b00, 2'b00, 2'b00, 2'b01, 4'd0, 4'b0000));
            nextCyc();
        end
        mem_ready = 1'b1;
        chk({tag, "-write"}, mk(5'b01010, 2'b00, 2'b00, 2'b00, 2'b01, 4'd0, 4'b0100));
        nextCyc();
    endtask

    initial begin
        reset = 1'b1;
        op = 7'b0110011; f3 = 3'b000; f7 = 1'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
        doReset("reset0", vFetchGo(2'b00));

        runR("add",  7'b0110011, 3'b000, 1'b0, 4'd0);
        runR("sub",  7'b0110011, 3'b000, 1'b1, 4'd1);
        runR("xor",  7'b0110011, 3'b100, 1'b0, 4'd4);
        runR("sltu", 7'b0110011, 3'b011, 1'b0, 4'd6);
        runR("srai", 7'b0010011, 3'b101, 1'b1, 4'd9);
        runR("addi", 7'b0010011, 3'b000, 1'b1, 4'd0);
        runR("andi", 7'b0010011, 3'b111, 1'b0, 4'd2);

        runBr("bne-tk",  3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        runBr("bne-nt",  3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        runBr("bltu-tk", 3'b110, 1'b0, 1'b0, 1'b1, 1'b1);
        runBr("beq-tk",  3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        runBr("bge-nt",  3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
        runBr("f3010-nt", 3'b010, 1'b1, 1'b1, 1'b1, 1'b0);

        // jal
        op = 7'b1101111; mem_ready = 1'b1;
        chk("jal-fetch", vFetchGo(2'b11));
        nextCyc();
        chk("jal-decode", vDecode(2'b11, 1'b0));
        nextCyc();
        chk("jal-jal", mk(5'b10000, 2'b00, 2'b01, 2'b10, 2'b11, 4'd0, 4'b0000));
        nextCyc();
        chk("jal-wb", vAluWb(2'b11));
        nextCyc();

        runLw("lw",      0, 0);
        runLw("lw-w3",   0, 3);
        runLw("lw-long", 10, 14);
        runSw("sw",      0);
        runSw("sw-w2",   2);

        // Unknown opcode
        op = 7'b0000000; mem_ready = 1'b1;
        chk("ill-fetch", vFetchGo(2'b00));
        nextCyc();
`ifdef UC_MC_ILLEGAL_TRAP_EN
        chk("ill-decode", vDecode(2'b00, 1'b0));
        nextCyc();
        chk("ill-trap", mk(5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 4'b0001));
        nextCyc();
        chk("ill-held", mk(5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 4'b0001));
        doReset("ill-rst", vFetchGo(2'b00));
`else
        chk("ill-nop", vDecode(2'b00, 1'b1));
        nextCyc();
        chk("ill-refetch", vFetchGo(2'b00));
`endif

        // Reset in the middle of a load's memory read
        op = 7'b0000011; f3 = 3'b010; mem_ready = 1'b1;
        chk("mid-fetch", vFetchGo(2'b00));
        nextCyc();
        nextCyc();
        chk("mid-memadr", mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 4'd0, 4'b0000));
        nextCyc();
        mem_ready = 1'b0;
        chk("mid-read", mk(5'b01100, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 4'b0000));
        doReset("mid-rst", vFetchWait(2'b00));
        nextCyc();
        chk("mid-still-fetch", vFetchWait(2'b00));
        nextCyc();

        // Limit cycle with mem_ready high: no error
        doReset("lim-rst", vFetchWait(2'b00));
        op = 7'b0110011; f3 = 3'b000; f7 = 1'b0;
        for (int i = 0; i < 13; i++) begin
            nextCyc();
            chk("lim-wait", vFetchWait(2'b00));
        end
        nextCyc();
        runR("lim-add", 7'b0110011, 3'b000, 1'b0, 4'd0);

        // Stuck mem_ready: 15 waiting cycles then bus error
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("to-wait", vFetchWait(2'b00));
            nextCyc();
        end
        chk("to-err", mk(5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 4'b0010));
        nextCyc();
        mem_ready = 1'b1;
        chk("to-sticky", mk(5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 4'b0010));
        nextCyc();
        chk("to-sticky2", mk(5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 4'b0010));
        doReset("to-rst", vFetchGo(2'b00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/uc_multicycle.md
Name: uc_multicycle

Overview:
- Multicycle control unit for the rv32i core; next generation of the single-cycle control unit.
- Moore FSM sequences fetch/decode/execute/memory/writeback over several cycles around a shared memory port.
- Adds:
  - a memory ready handshake with timeout,
  - the full RV32I branch set (beq/bne/blt/bge/bltu/bgeu),
  - an extended ALU operation set.
- Drives PC, IR, mux selects and register file write enables of the multicycle datapath.

Parameters:
- ALU_CTRL_W, 4, width of ALUControl; must be >= 4.
- MEM_TIMEOUT, 15, cycles a memory access may wait for mem_ready before bus error; 0 disables the timeout.
- TO_CNT_W, 4, timeout counter width; must satisfy MEM_TIMEOUT < 2^TO_CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  7  instruction opcode (IR[6:0]).
- f3  in  3  funct3.
- f7  in  1  funct7 bit 5.
- zero  in  1  ALU result == 0.
- lt  in  1  signed rs1 < rs2.
- ltu  in  1  unsigned rs1 < rs2.
- mem_ready  in  1  memory completes the current access this cycle.
- pcWrite  out  1  PC register load.
- adrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memRead  out  1  memory read request.
- memWrite  out  1  memory write request.
- irWrite  out  1  IR and oldPC load.
- resSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- aluSrcA  out  2  A mux: 00 = PC, 01 = oldPC, 10 = rs1.
- aluSrcB  out  2  B mux: 00 = rs2, 01 = imm, 10 = const 4.
- inmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  ALU_CTRL_W  ALU operation.
- regWrite  out  1  register file write.
- instr_done  out  1  one-cycle pulse at instruction retire.
- bus_err  out  1  sticky error flag; held until reset.
- illegal  out  1  illegal opcode indication; see Optional Feature.

Behaviour:
- Reset:
  - Asynchronous; state <= FETCH, timeout counter <= 0, bus_err <= 0.
  - While reset is high, every output is forced to 0.
- Outputs are combinational from state, op, f3, f7, flags and mem_ready only. No output is registered.
- ALUControl codes: add 0, sub 1, and 2, or 3, xor 4, slt 5, sltu 6, sll 7, srl 8, sra 9. Zero-extended to ALU_CTRL_W.
- ALU op classes:
  - 00 = add.
  - 01 = sub.
  - 10 = decode from f3 as follows:
    - f3 000: sub when op[5] & f7, else add.
    - f3 001: sll.
    - f3 010: slt.
    - f3 011: sltu.
    - f3 100: xor.
    - f3 101: sra when f7, else srl.
    - f3 110: or.
    - f3 111: and.
- inmSrc is derived from op in every state: I for 0000011/0010011, S for 0100011, B for 1100011, J for 1101111, else 00.
- States and transitions:
  - FETCH: adrSrc=0, memRead=1.
    - While !mem_ready: stay.
    - On mem_ready: irWrite=1, A=00, B=10, add, resSrc=10, pcWrite=1 -> DECODE.
  - DECODE: A=01, B=01, add (branch/jump target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR.
    - 0110011 -> EXECR.
    - 0010011 -> EXECI.
    - 1101111 -> JAL.
    - 1100011 -> BRANCH.
    - Other opcodes: see Optional Feature.
  - MEMADR: A=10, B=01, add -> MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: adrSrc=1, memRead=1; wait for mem_ready -> MEMWB.
  - MEMWB: resSrc=01, regWrite=1, instr_done=1 -> FETCH.
  - MEMWRITE: adrSrc=1, memWrite=1; wait for mem_ready; then instr_done=1 -> FETCH.
  - EXECR: A=10, B=00, class 10 -> ALUWB.
  - EXECI: A=10, B=01, class 10 with op[5]=0 -> ALUWB.
  - ALUWB: resSrc=00, regWrite=1, instr_done=1 -> FETCH.
  - JAL: A=01, B=10, add, resSrc=00, pcWrite=1 -> ALUWB (rd <- oldPC+4).
  - BRANCH: A=10, B=00, sub, resSrc=00, instr_done=1 -> FETCH.
    - pcWrite = taken.
    - taken by f3: 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010/011 never taken.
  - ERR: all outputs 0 except bus_err=1; stays until reset.
- Timeout:
  - Counter increments each cycle in FETCH, MEMREAD or MEMWRITE with !mem_ready.
  - Cleared on any state change.
  - When the count reaches MEM_TIMEOUT with mem_ready still low -> ERR.
  - mem_ready in the same cycle as the limit wins; no error.
- Per-instruction latency with mem_ready always 1:
  - lw 5 cycles; sw 4; R/I 4; jal 4; branch 3.

Optional Feature:
- Macro: UC_MC_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE -> TRAP state.
  - illegal=1, all other outputs 0.
  - Held until reset.
- Undefined: an unknown opcode executes as a NOP.
  - DECODE -> FETCH with instr_done=1.
  - illegal tied to 0; TRAP state absent.

Decomposition:
- Package uc_mc_pkg holds:
  - state encoding;
  - opcode constants;
  - ALUControl codes;
  - ALU op class codes;
  - aluSrcA/aluSrcB/resSrc/inmSrc select codes.
- One sub-module: alu_deco_ext (combinational ALU op class + op[5]/f3/f7 -> ALUControl). Instantiated once.
- The FSM, timeout counter and branch resolution stay in uc_multicycle.

Test Plan:
- Reset mid-MEMREAD -> state FETCH immediately, all outputs 0 during reset; after release memRead=1, adrSrc=0.
- add x1,x2,x3 (op 0110011, f3 000, f7 0), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB; ALUControl=0 in EXECR; regWrite=1 only in ALUWB; instr_done on cycle 4.
- sub (f7=1) and srai (op 0010011, f3 101, f7=1) -> ALUControl 1 and 9 respectively.
- bne with zero=0 -> pcWrite=1 in BRANCH; with zero=1 -> pcWrite=0. bltu with ltu=1 -> pcWrite=1.
- lw with mem_ready low 3 cycles in MEMREAD -> memRead held 4 cycles, then MEMWB resSrc=01, regWrite=1; total 8 cycles.
- mem_ready stuck low in FETCH, MEM_TIMEOUT=15 -> ERR after 15 waiting cycles, bus_err=1 until reset. With the macro defined, op 0000000 -> illegal=1, held.
